// File: rtl/sram_cell_pkg.sv
// Shared types and limits for the SRAM cell sequencer and its arbiter.
package sram_cell_pkg;
    localparam int MAX_DEPTH = 16;
    localparam int MAX_PULSE = 7;
    localparam int CNT_W     = $clog2(MAX_PULSE + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WSTROBE,
        WHOLD,
        RSTROBE,
        SAMPLE
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;
endpackage

// File: rtl/sram_rr_arb.sv
// Two-requester round-robin arbiter; the last-grant pointer resets to B so A wins first.
module sram_rr_arb
    import sram_cell_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);
    req_id_e last_q, last_d;

    always_comb begin
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        last_d  = last_q;
        if (en_i) begin
            if (req_a_i && req_b_i) begin
                gnt_a_o = (last_q == REQ_B);
                gnt_b_o = (last_q == REQ_A);
            end else begin
                gnt_a_o = req_a_i;
                gnt_b_o = req_b_i;
            end
            if (gnt_a_o) begin
                last_d = REQ_A;
            end else if (gnt_b_o) begin
                last_d = REQ_B;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/sram_cell_seq.sv
// Sequences strobed write/read accesses to an SRAM cell array for two requesters.
// Define READBACK_VERIFY_EN to re-read each write and report a miscompare on err.
module sram_cell_seq
    import sram_cell_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int WR_PULSE = 2,
    parameter int RD_PULSE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             we_a,
    input  logic             we_b,
    input  logic [3:0]       addr_a,
    input  logic [3:0]       addr_b,
    input  logic [WIDTH-1:0] wdata_a,
    input  logic [WIDTH-1:0] wdata_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic             err,
    output logic [WIDTH-1:0] rdata,
    output logic [DEPTH-1:0] row_sel,
    output logic             cell_write,
    output logic [WIDTH-1:0] cell_data,
    output logic             cell_read,
    input  logic [WIDTH-1:0] cell_q
);
    localparam logic [4:0]       DEPTH_L = 5'(DEPTH);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_PULSE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [3:0]       addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    req_id_e          id_q, id_d;
    logic             ack_a_q, ack_a_d, ack_b_q, ack_b_d, err_q, err_d;
    logic [WIDTH-1:0] rdata_q, rdata_d, cell_data_q, cell_data_d;
    logic [DEPTH-1:0] row_sel_q, row_sel_d, row_dec;
    logic             cell_write_q, cell_write_d, cell_read_q, cell_read_d;
    logic             gnt_a, gnt_b;

    // A requester still holds req during its ack cycle; mask it so it is not served twice.
    sram_rr_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (state_q == IDLE),
        .req_a_i (req_a & ~ack_a_q),
        .req_b_i (req_b & ~ack_b_q),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b)
    );

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row_dec
        assign row_dec[gi] = (addr_d == 4'(gi));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        id_d    = id_q;
        ack_a_d = 1'b0;
        ack_b_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_a || gnt_b) begin
                    id_d    = gnt_b ? REQ_B : REQ_A;
                    we_d    = gnt_b ? we_b : we_a;
                    addr_d  = gnt_b ? addr_b : addr_a;
                    wdata_d = gnt_b ? wdata_b : wdata_a;
                    if ({1'b0, addr_d} >= DEPTH_L) begin
                        ack_a_d = gnt_a;
                        ack_b_d = gnt_b;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = we_q ? WSTROBE : RSTROBE;
                cnt_d   = we_q ? WR_LOAD : RD_LOAD;
            end
            WSTROBE: begin
                if (cnt_q == '0) state_d = WHOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            WHOLD: begin
`ifdef READBACK_VERIFY_EN
                state_d = RSTROBE;
                cnt_d   = RD_LOAD;
`else
                state_d = IDLE;
                ack_a_d = (id_q == REQ_A);
                ack_b_d = (id_q == REQ_B);
`endif
            end
            RSTROBE: begin
                if (cnt_q == '0) state_d = SAMPLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            SAMPLE: begin
                state_d = IDLE;
                ack_a_d = (id_q == REQ_A);
                ack_b_d = (id_q == REQ_B);
`ifdef READBACK_VERIFY_EN
                if (we_q) err_d   = (cell_q != wdata_q);
                else      rdata_d = cell_q;
`else
                rdata_d = cell_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Array-side outputs are registered from the next state so they change cleanly on the edge.
    always_comb begin
        row_sel_d    = (state_d == IDLE) ? '0 : row_dec;
        cell_write_d = (state_d == WSTROBE);
        cell_read_d  = (state_d == RSTROBE);
        cell_data_d  = '0;
        if (we_d && (state_d inside {SETUP, WSTROBE, WHOLD})) begin
            cell_data_d = wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            id_q         <= REQ_A;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            row_sel_q    <= '0;
            cell_write_q <= 1'b0;
            cell_read_q  <= 1'b0;
            cell_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            id_q         <= id_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            row_sel_q    <= row_sel_d;
            cell_write_q <= cell_write_d;
            cell_read_q  <= cell_read_d;
            cell_data_q  <= cell_data_d;
        end
    end

    assign ack_a      = ack_a_q;
    assign ack_b      = ack_b_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign row_sel    = row_sel_q;
    assign cell_write = cell_write_q;
    assign cell_read  = cell_read_q;
    assign cell_data  = cell_data_q;
endmodule

// File: tb/tb_sram_cell_seq.sv
// Self-checking bench for sram_cell_seq with a behavioural cell array and reference memory.
module tb_sram_cell_seq;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 12;
    localparam int WR_PULSE = 2;
    localparam int RD_PULSE = 1;
`ifdef READBACK_VERIFY_EN
    localparam int WLAT   = WR_PULSE + RD_PULSE + 4;
    localparam bit VERIFY = 1'b1;
`else
    localparam int WLAT   = WR_PULSE + 3;
    localparam bit VERIFY = 1'b0;
`endif
    localparam int RLAT = RD_PULSE + 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [3:0]       addr_a = '0, addr_b = '0;
    logic [WIDTH-1:0] wdata_a = '0, wdata_b = '0;
    logic             ack_a, ack_b, err, cell_write, cell_read;
    logic [WIDTH-1:0] rdata, cell_data, cell_q;
    logic [DEPTH-1:0] row_sel;

    sram_cell_seq #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .WR_PULSE(WR_PULSE), .RD_PULSE(RD_PULSE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b), .err(err), .rdata(rdata),
        .row_sel(row_sel), .cell_write(cell_write), .cell_data(cell_data),
        .cell_read(cell_read), .cell_q(cell_q)
    );

    always #5 clk = ~clk;

    // Behavioural cell array; stuck0 forces bit 0 of the Q lines low.
    logic [WIDTH-1:0] cells [16];
    bit               stuck0 = 1'b0;
    initial for (int i = 0; i < 16; i++) cells[i] = '0;

    always @(posedge clk) begin
        if (cell_write) begin
            for (int i = 0; i < DEPTH; i++) if (row_sel[i]) cells[i] <= cell_data;
        end
    end

    always_comb begin
        cell_q = '0;
        for (int i = 0; i < DEPTH; i++) if (row_sel[i]) cell_q = cells[i];
        if (stuck0) cell_q[0] = 1'b0;
    end

    // Reference model: expected array contents and the last value returned by a read.
    logic [WIDTH-1:0] mem_ref [16];
    logic [WIDTH-1:0] last_rd = '0;
    initial for (int i = 0; i < 16; i++) mem_ref[i] = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            logic bad_mon;
            bad_mon = (cell_write && cell_read) ||
                      ((cell_write || cell_read) && (row_sel == '0)) ||
                      !$onehot0(row_sel);
            chk("strobe_rules", 32'(bad_mon), 32'd0);
        end
    end

    task automatic run_and_check(input bit port, input bit we, input logic [3:0] addr,
                                 input logic [7:0] wd, input bit exp_err,
                                 input logic [7:0] exp_rd, input int exp_lat);
        int          lat, nwr, nrd, exp_nwr, exp_nrd;
        bit          got, other, bad;
        logic        e;
        logic [7:0]  rd;
        logic [15:0] rows, exp_rows;
        bad = (addr >= DEPTH);
        lat = 0; nwr = 0; nrd = 0; got = 0; other = 0; e = 0; rd = '0; rows = '0;
        if (port) begin req_b = 1; we_b = we; addr_b = addr; wdata_b = wd; end
        else      begin req_a = 1; we_a = we; addr_a = addr; wdata_a = wd; end
        while (!got && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (cell_write) nwr++;
            if (cell_read)  nrd++;
            rows |= 16'(row_sel);
            if (port ? ack_a : ack_b) other = 1;
            if (port ? ack_b : ack_a) begin got = 1; e = err; rd = rdata; end
        end
        if (port) req_b = 0; else req_a = 0;
        $display("txn port=%s we=%0d addr=%0d wd=%02h -> lat=%0d err=%0d rdata=%02h",
                 port ? "B" : "A", we, addr, wd, lat, e, rd);
        exp_nwr  = (we && !bad) ? WR_PULSE : 0;
        exp_nrd  = (!bad && (!we || VERIFY)) ? RD_PULSE : 0;
        exp_rows = bad ? 16'd0 : (16'd1 << addr);
        chk("acked", 32'(got), 32'd1);
        chk("latency", lat, exp_lat);
        chk("err", 32'(e), 32'(exp_err));
        chk("rdata", 32'(rd), 32'(exp_rd));
        chk("wstrobe_cycles", nwr, exp_nwr);
        chk("rstrobe_cycles", nrd, exp_nrd);
        chk("row_sel_seen", 32'(rows), 32'(exp_rows));
        chk("wrong_port_ack", 32'(other), 32'd0);
        if (!bad && we)  mem_ref[addr] = wd;
        if (!bad && !we) last_rd = exp_rd;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        last_rd = '0;
    endtask

    typedef struct {
        bit         port;
        bit         we;
        logic [3:0] addr;
        logic [7:0] wd;
        bit         exp_err;
        logic [7:0] exp_rd;
        int         exp_lat;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         order [4];
        int         n, cyc, rem_a, rem_b;
        bit         seen, ackseen;

        tbl[0] = '{1'b0, 1'b1, 4'd3,  8'hA5, 1'b0, 8'h00, WLAT};
        tbl[1] = '{1'b0, 1'b0, 4'd3,  8'h00, 1'b0, 8'hA5, RLAT};
        tbl[2] = '{1'b1, 1'b1, 4'd11, 8'h3C, 1'b0, 8'hA5, WLAT};
        tbl[3] = '{1'b1, 1'b0, 4'd11, 8'h00, 1'b0, 8'h3C, RLAT};
        tbl[4] = '{1'b1, 1'b0, 4'd13, 8'h00, 1'b1, 8'h3C, 1};
        tbl[5] = '{1'b0, 1'b1, 4'd12, 8'hFF, 1'b1, 8'h3C, 1};
        tbl[6] = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 8'h00, RLAT};
        tbl[7] = '{1'b1, 1'b0, 4'd3,  8'h00, 1'b0, 8'hA5, RLAT};
        tbl[8] = '{1'b1, 1'b1, 4'd0,  8'h5A, 1'b0, 8'hA5, WLAT};
        tbl[9] = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 8'h5A, RLAT};

        // Outputs are all low while reset is held and stay quiet once released.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {30'd0, ack_a, ack_b}, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_row_sel", 32'(row_sel), 32'd0);
        chk("rst_strobes", {30'd0, cell_write, cell_read}, 32'd0);
        chk("rst_cell_data", 32'(cell_data), 32'd0);
        rst_n = 1;
        @(posedge clk); #1;
        chk("idle_after_rst", {30'd0, ack_a, ack_b}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_and_check(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wd,
                          tbl[i].exp_err, tbl[i].exp_rd, tbl[i].exp_lat);
        end

        // Simultaneous requests straight out of reset: A, then B, alternating.
        do_reset();
        for (int i = 0; i < 4; i++) order[i] = 9;
        n = 0; cyc = 0; rem_a = 2; rem_b = 2;
        we_a = 0; addr_a = 4'd3; we_b = 0; addr_b = 4'd11;
        req_a = 1; req_b = 1;
        while ((rem_a > 0 || rem_b > 0) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (ack_a) begin
                if (n < 4) order[n] = 0;
                n++; rem_a--; req_a = 0;
                chk("cont_rdata_a", 32'(rdata), 32'(mem_ref[3]));
            end else if (rem_a > 0) req_a = 1;
            if (ack_b) begin
                if (n < 4) order[n] = 1;
                n++; rem_b--; req_b = 0;
                chk("cont_rdata_b", 32'(rdata), 32'(mem_ref[11]));
            end else if (rem_b > 0) req_b = 1;
        end
        req_a = 0; req_b = 0;
        $display("txn contention acks=%0d order=%0d%0d%0d%0d", n, order[0], order[1], order[2], order[3]);
        chk("cont_count", n, 4);
        for (int i = 0; i < 4; i++) chk("cont_order", order[i], i % 2);
        last_rd = mem_ref[11];
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            bit         p, w, be;
            logic [3:0] a;
            logic [7:0] d, er;
            int         el;
            p  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom_range(0, 255));
            be = (a >= DEPTH);
            if (be)     begin er = last_rd;    el = 1;    end
            else if (w) begin er = last_rd;    el = WLAT; end
            else        begin er = mem_ref[a]; el = RLAT; end
            run_and_check(p, w, a, d, be, er, el);
        end

        // Reset in the middle of a write strobe aborts the access without an ack.
        req_a = 1; we_a = 1; addr_a = 4'd5; wdata_a = 8'h77;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (cell_write) seen = 1;
        end
        chk("saw_wstrobe", 32'(seen), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("midrst_cell_write", 32'(cell_write), 32'd0);
        chk("midrst_row_sel", 32'(row_sel), 32'd0);
        chk("midrst_cell_data", 32'(cell_data), 32'd0);
        req_a = 0;
        ackseen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst_n = 1;
            if (ack_a || ack_b) ackseen = 1;
        end
        $display("txn reset during write: ack seen=%0d", ackseen);
        chk("midrst_no_ack", 32'(ackseen), 32'd0);
        last_rd = '0;
        run_and_check(1'b0, 1'b1, 4'd5, 8'h77, 1'b0, 8'h00, WLAT);
        run_and_check(1'b0, 1'b0, 4'd5, 8'h00, 1'b0, 8'h77, RLAT);

`ifdef READBACK_VERIFY_EN
        stuck0 = 1'b1;
        run_and_check(1'b0, 1'b1, 4'd2, 8'h01, 1'b1, last_rd, WLAT);
        run_and_check(1'b0, 1'b1, 4'd2, 8'h02, 1'b0, last_rd, WLAT);
        stuck0 = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_cell_seq.md
SRAM_CELL_SEQ -- requirements
Module: sram_cell_seq

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data bits per word.
REQ-002 The block SHALL have parameter DEPTH, default 16 (range 2..16), giving the words (rows) of the cell array.
REQ-003 The block SHALL have parameter WR_PULSE, default 2 (range 1..7), giving the write strobe width in cycles.
REQ-004 The block SHALL have parameter RD_PULSE, default 1 (range 1..7), giving the cycles from read strobe assert to sample.

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all logic SHALL run on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have ports req_a / req_b, input, 1 bit each: access request, held high until the matching ack.
REQ-008 The block SHALL have ports we_a / we_b, input, 1 bit each: 1 = write, 0 = read.
REQ-009 The block SHALL have ports addr_a / addr_b, input, 4 bits each: word address.
REQ-010 The block SHALL have ports wdata_a / wdata_b, input, WIDTH bits each: write data.
REQ-011 The block SHALL have ports ack_a / ack_b, output, 1 bit each: one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1 bit: valid with ack; high on bad address (or verify miscompare).
REQ-013 The block SHALL have port rdata, output, WIDTH bits: read data, valid in the ack cycle.
REQ-014 The block SHALL have port row_sel, output, DEPTH bits: one-hot row enable to the array.
REQ-015 The block SHALL have port cell_write, output, 1 bit: cell Write gate (pass transistor on).
REQ-016 The block SHALL have port cell_data, output, WIDTH bits: cell Data lines.
REQ-017 The block SHALL have port cell_read, output, 1 bit: cell Read gate.
REQ-018 The block SHALL have port cell_q, input, WIDTH bits: cell Q lines from the selected row.

Function
REQ-019 The FSM SHALL have states IDLE, SETUP, WSTROBE, WHOLD, RSTROBE, SAMPLE, with one access in flight at a time.
REQ-020 In IDLE with any req high, the arbiter SHALL grant and latch we/addr/wdata, then go to SETUP next cycle.
REQ-021 With both reqs high, the arbiter SHALL grant the requester not served last; the pointer SHALL reset to favour A.
REQ-022 SETUP SHALL drive row_sel and cell_data with strobes low for one cycle, then go to WSTROBE if write, else RSTROBE.
REQ-023 WSTROBE SHALL hold cell_write=1 for exactly WR_PULSE cycles, then go to WHOLD.
REQ-024 WHOLD SHALL drop cell_write while keeping row_sel and cell_data for one cycle, then pulse ack and return to IDLE.
REQ-025 RSTROBE SHALL hold cell_read=1 for RD_PULSE cycles, then go to SAMPLE.
REQ-026 SAMPLE SHALL register cell_q into rdata, drop cell_read, pulse ack, and return to IDLE.
REQ-027 Latency from grant to ack SHALL be WR_PULSE+3 cycles for a write and RD_PULSE+3 cycles for a read.
REQ-028 cell_write and cell_read SHALL never be high together, and neither SHALL be high unless row_sel is nonzero.
REQ-029 If addr >= DEPTH, the block SHALL pulse ack with err=1 one cycle after grant, with no array access and rdata unchanged.
REQ-030 A req dropped before grant SHALL be ignored; a req dropped after grant SHALL NOT abort the access, and ack SHALL still pulse.
REQ-031 After an ack, that requester SHALL NOT be regranted in the same cycle; IDLE SHALL last at least one cycle.
REQ-032 rdata SHALL hold its last value between reads.

Reset
REQ-033 While rst_n is low, the block SHALL asynchronously force the state to IDLE, all outputs to 0, and the pointer to A, including mid-access.
REQ-034 An access interrupted by reset SHALL produce no ack; the array contents after the interrupted access are undefined.

Configuration
REQ-035 With READBACK_VERIFY_EN defined, each write SHALL go WHOLD -> RSTROBE -> SAMPLE, compare cell_q to the latched wdata, and set err=1 on mismatch; write latency SHALL become WR_PULSE+RD_PULSE+4 cycles.
REQ-036 Without READBACK_VERIFY_EN, write err SHALL be 0 for valid addresses, and the verify path SHALL be absent.

Structure
REQ-037 A package sram_cell_pkg SHALL hold the state enum, the requester-id type, and constants MAX_DEPTH=16 and MAX_PULSE=7.
REQ-038 One sub-module, sram_rr_arb (two-requester round-robin arbiter with last-grant pointer), SHALL be used.

Verification
REQ-039 Scenario 1: A writes 0xA5 to addr 3, WR_PULSE=2 -> cell_write high for exactly 2 cycles with row_sel=0x0008, and ack_a 5 cycles after grant with err=0.
REQ-040 Scenario 2: A reads addr 3 after scenario 1 (model returns stored value) -> rdata=0xA5 with ack_a 4 cycles after grant.
REQ-041 Scenario 3: req_a and req_b rise in the same cycle from reset -> A is granted first, then B, and repeated contention alternates.
REQ-042 Scenario 4: DEPTH=12, B reads addr 13 -> ack_b with err=1 one cycle after grant, with no strobe or row_sel activity.
REQ-043 Scenario 5: rst_n pulled low during WSTROBE -> cell_write and row_sel are 0 immediately, no ack occurs, and the next request works normally.
REQ-044 Scenario 6 (READBACK_VERIFY_EN defined): the model sticks bit 0 at 0 and A writes 0x01 -> ack_a with err=1 at WR_PULSE+RD_PULSE+4 cycles.
